// File: rtl/audio_pwm_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pwm_out_if
//  Description : Sample fetch link between the music ROM / address machine
//                and the PWM audio output stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface audio_pwm_out_if;
    logic [7:0] sample;      // current ROM data word, unsigned offset-binary
    logic       sample_req;  // one-cycle pulse: advance to the next sample

    // Address machine / ROM side
    modport master (output sample, input sample_req);
    // PWM output stage side
    modport slave  (input sample, output sample_req);
endinterface
`default_nettype wire

// File: rtl/audio_pwm_out.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pwm_out
//  Description : Scales each 8-bit ROM sample by the BCD volume and emits it
//                as a fixed-period PWM waveform, requesting one sample per
//                period. Paused playback is silent and requests nothing.
//  Revision    : 1.0  initial release
// ============================================================================
module audio_pwm_out #(
    parameter int VOL_MAX = 10
) (
    input  wire logic           clk,
    input  wire logic           reset,
    audio_pwm_out_if.slave      bus,
    input  wire logic           play,
    input  wire logic [3:0]     volume1,
    input  wire logic [3:0]     volume0,
    output logic                pwm_out,
    output logic                active
);

    // Period is tied to full-scale sample times max volume so that a
    // full-scale product maps to a 100% duty cycle.
    localparam int PERIOD = 255 * VOL_MAX;
    localparam int CW     = $clog2(PERIOD + 1);

    localparam logic [CW-1:0] c_LAST    = CW'(PERIOD - 1);
    localparam logic [CW-1:0] c_CAPTURE = CW'(2);
    localparam logic [6:0]    c_VOL_MAX = 7'(VOL_MAX);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_duty;
    logic [CW-1:0]   r_pend_duty;
    logic            r_pwm;
    logic            r_req;
    logic            r_active;

    logic [3:0]      w_digit1;
    logic [3:0]      w_digit0;
    logic [6:0]      w_vol_raw;
    logic [6:0]      w_vol;
    logic [14:0]     w_product;
    logic [CW-1:0]   w_scale;

    // BCD volume decode: saturate bad digits to 9, clamp to VOL_MAX, then
    // scale the current sample. The product never exceeds PERIOD.
    always_comb begin
        w_digit1  = (volume1 > 4'd9) ? 4'd9 : volume1;
        w_digit0  = (volume0 > 4'd9) ? 4'd9 : volume0;
        w_vol_raw = 7'(w_digit1) * 7'd10 + 7'(w_digit0);
        w_vol     = (w_vol_raw > c_VOL_MAX) ? c_VOL_MAX : w_vol_raw;
        w_product = 15'(bus.sample) * 15'(w_vol);
        w_scale   = w_product[CW-1:0];
    end

    // Playback state machine, PWM counter and sample-request generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_duty      <= '0;
            r_pend_duty <= '0;
            r_pwm       <= 1'b0;
            r_req       <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pwm <= 1'b0;
                    r_cnt <= '0;
                    r_req <= 1'b0;
                    if (play) begin
                        // Entry plays the current address immediately and
                        // requests the next one.
                        r_state     <= RUN;
                        r_duty      <= w_scale;
                        r_pend_duty <= w_scale;
                        r_req       <= 1'b1;
                        r_active    <= 1'b1;
                    end
                end
                RUN: begin
                    if (!play) begin
                        // Pause discards the partial period; pause also wins
                        // over a coincident wrap, so no request escapes.
                        r_state  <= IDLE;
                        r_pwm    <= 1'b0;
                        r_cnt    <= '0;
                        r_req    <= 1'b0;
                        r_active <= 1'b0;
                    end else begin
                        r_pwm <= (r_cnt < r_duty);
                        if (r_cnt == c_LAST) begin
                            r_cnt  <= '0;
                            r_duty <= r_pend_duty;
                            r_req  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_req <= 1'b0;
                        end
                        // Address moves at cnt 1, ROM output is stable by
                        // cnt 2: latch the sample for the next period here.
                        if (r_cnt == c_CAPTURE) begin
                            r_pend_duty <= w_scale;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sample_req = r_req;
    assign pwm_out        = r_pwm;
    assign active         = r_active;

endmodule
`default_nettype wire
